// File: rtl/ste_shift_pkg.sv
// rtl/ste_shift_pkg.sv - shared FSM state type and default width for the shift sequencer
package ste_shift_pkg;

    localparam int STE_SHIFT_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } ste_shift_seq_state_e;

endpackage

// File: rtl/ste_shift_seq.sv
// rtl/ste_shift_seq.sv - word sequencer driving an external shift register (optional parity bit via STE_SHIFT_SEQ_PARITY_EN)
module ste_shift_seq
    import ste_shift_pkg::*;
#(
    parameter int SHIFT_W = STE_SHIFT_W_DEF,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [SHIFT_W-1:0] word_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    input  logic               load_mode_i,
    input  logic [GAP_W-1:0]   gap_cycles_i,
    input  logic               clr_req_i,
    output logic               din_o,
    output logic [SHIFT_W-1:0] din_parallel_o,
    output logic               shift_en_o,
    output logic               shift_ld_o,
    output logic               shift_clr_o,
    output logic [15:0]        word_cnt_o
);

    // One down-counter serves both the bit position in SHIFT and the idle count in GAP,
    // so it must hold the larger of the two ranges.
    localparam int CNT_MAX = (SHIFT_W + 1 > (1 << GAP_W)) ? SHIFT_W + 1 : (1 << GAP_W);
    localparam int CNT_W   = $clog2(CNT_MAX);

    // Counter value loaded at accept: remaining shift cycles after the first one.
`ifdef STE_SHIFT_SEQ_PARITY_EN
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_W);
`else
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_W - 1);
`endif

    ste_shift_seq_state_e state, state_nxt;
    logic [SHIFT_W-1:0]   word_q, word_nxt;
    logic [GAP_W-1:0]     gap_q, gap_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 clr_pend, clr_pend_nxt;
    logic                 din_nxt;
    logic [SHIFT_W-1:0]   din_parallel_nxt;
    logic                 shift_en_nxt;
    logic                 shift_ld_nxt;
    logic                 shift_clr_nxt;
    logic [15:0]          word_cnt_nxt;
    logic                 word_done;
    logic [CNT_W-1:0]     cnt_dec;

    assign word_ready_o = (state == ST_IDLE) && !clr_pend && !clr_req_i;
    assign cnt_dec      = cnt - 1'b1;

    // Next-state and next-output logic; every control output is registered from these.
    always_comb begin
        state_nxt        = state;
        word_nxt         = word_q;
        gap_nxt          = gap_q;
        cnt_nxt          = cnt;
        clr_pend_nxt     = clr_pend;
        din_nxt          = 1'b0;
        din_parallel_nxt = '0;
        shift_en_nxt     = 1'b0;
        shift_ld_nxt     = 1'b0;
        shift_clr_nxt    = 1'b0;
        word_cnt_nxt     = word_cnt_o;
        word_done        = 1'b0;

        // Requests arriving mid-word are remembered; a clear already in progress absorbs them.
        if (clr_req_i && (state != ST_IDLE) && (state != ST_CLEAR)) begin
            clr_pend_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (clr_req_i || clr_pend) begin
                    state_nxt     = ST_CLEAR;
                    shift_clr_nxt = 1'b1;
                    clr_pend_nxt  = 1'b0;
                end else if (word_valid_i) begin
                    word_nxt = word_i;
                    gap_nxt  = gap_cycles_i;
                    if (load_mode_i) begin
                        state_nxt        = ST_LOAD;
                        shift_ld_nxt     = 1'b1;
                        din_parallel_nxt = word_i;
                    end else begin
                        state_nxt    = ST_SHIFT;
                        shift_en_nxt = 1'b1;
                        din_nxt      = word_i[SHIFT_W-1];
                        cnt_nxt      = SHIFT_LAST;
                    end
                end
            end
            ST_CLEAR: begin
                state_nxt    = ST_IDLE;
                clr_pend_nxt = 1'b0;
            end
            ST_LOAD: begin
                word_done = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt != '0) begin
                    shift_en_nxt = 1'b1;
                    cnt_nxt      = cnt_dec;
`ifdef STE_SHIFT_SEQ_PARITY_EN
                    if (cnt == CNT_W'(1)) begin
                        din_nxt = ^word_q;
                    end else begin
                        din_nxt = word_q[cnt - CNT_W'(2)];
                    end
`else
                    din_nxt = word_q[cnt_dec];
`endif
                end else begin
                    word_done = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (word_done) begin
            word_cnt_nxt = word_cnt_o + 16'd1;
            if (gap_q == '0) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_GAP;
                cnt_nxt   = CNT_W'(gap_q - 1'b1);
            end
        end
    end

    // State and output registers; reset abandons any word in flight without counting it.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            word_q         <= '0;
            gap_q          <= '0;
            cnt            <= '0;
            clr_pend       <= 1'b0;
            din_o          <= 1'b0;
            din_parallel_o <= '0;
            shift_en_o     <= 1'b0;
            shift_ld_o     <= 1'b0;
            shift_clr_o    <= 1'b0;
            word_cnt_o     <= '0;
        end else begin
            state          <= state_nxt;
            word_q         <= word_nxt;
            gap_q          <= gap_nxt;
            cnt            <= cnt_nxt;
            clr_pend       <= clr_pend_nxt;
            din_o          <= din_nxt;
            din_parallel_o <= din_parallel_nxt;
            shift_en_o     <= shift_en_nxt;
            shift_ld_o     <= shift_ld_nxt;
            shift_clr_o    <= shift_clr_nxt;
            word_cnt_o     <= word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ste_shift_seq.sv
// tb/tb_ste_shift_seq.sv - directed self-checking bench for ste_shift_seq
module tb_ste_shift_seq;

    localparam int SHIFT_W = 24;
    localparam int GAP_W   = 4;
`ifdef STE_SHIFT_SEQ_PARITY_EN
    localparam int NBITS = SHIFT_W + 1;
`else
    localparam int NBITS = SHIFT_W;
`endif

    logic               clk;
    logic               reset_i;
    logic [SHIFT_W-1:0] word_i;
    logic               word_valid_i;
    logic               word_ready_o;
    logic               load_mode_i;
    logic [GAP_W-1:0]   gap_cycles_i;
    logic               clr_req_i;
    logic               din_o;
    logic [SHIFT_W-1:0] din_parallel_o;
    logic               shift_en_o;
    logic               shift_ld_o;
    logic               shift_clr_o;
    logic [15:0]        word_cnt_o;

    int checks;
    int errors;
    int exp_cnt;

    ste_shift_seq #(.SHIFT_W(SHIFT_W), .GAP_W(GAP_W)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .word_i         (word_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .load_mode_i    (load_mode_i),
        .gap_cycles_i   (gap_cycles_i),
        .clr_req_i      (clr_req_i),
        .din_o          (din_o),
        .din_parallel_o (din_parallel_o),
        .shift_en_o     (shift_en_o),
        .shift_ld_o     (shift_ld_o),
        .shift_clr_o    (shift_clr_o),
        .word_cnt_o     (word_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic send_word(input logic [SHIFT_W-1:0] w, input logic mode, input logic [GAP_W-1:0] gap);
        check("ready_before_send", word_ready_o, 1);
        word_i       = w;
        load_mode_i  = mode;
        gap_cycles_i = gap;
        word_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid_i = 1'b0;
    endtask

    // Checks every serial cycle MSB first (plus parity when enabled); pulses clr_req_i at clr_at.
    task automatic check_shift(input logic [SHIFT_W-1:0] w, input int clr_at);
        logic exp_bit;
        for (int k = 0; k < NBITS; k++) begin
            exp_bit = (k < SHIFT_W) ? w[SHIFT_W-1-k] : ^w;
            check($sformatf("shift_en[%0d]", k), shift_en_o, 1);
            check($sformatf("din[%0d]", k), din_o, exp_bit);
            check($sformatf("ld_in_shift[%0d]", k), shift_ld_o, 0);
            check($sformatf("ready_in_shift[%0d]", k), word_ready_o, 0);
            clr_req_i = (k == clr_at);
            @(negedge clk);
        end
        clr_req_i = 1'b0;
    endtask

    task automatic check_gap(input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("gap_en[%0d]", k), shift_en_o, 0);
            check($sformatf("gap_din[%0d]", k), din_o, 0);
            check($sformatf("gap_ld[%0d]", k), shift_ld_o, 0);
            check($sformatf("gap_clr[%0d]", k), shift_clr_o, 0);
            check($sformatf("gap_ready[%0d]", k), word_ready_o, 0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, word_ready_o, 1);
        check({tag, "_en"}, shift_en_o, 0);
        check({tag, "_din"}, din_o, 0);
        check({tag, "_cnt"}, word_cnt_o, exp_cnt);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_cnt      = 0;
        reset_i      = 1'b1;
        word_i       = '0;
        word_valid_i = 1'b0;
        load_mode_i  = 1'b0;
        gap_cycles_i = '0;
        clr_req_i    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;

        // reset state
        check("rst_en", shift_en_o, 0);
        check("rst_ld", shift_ld_o, 0);
        check("rst_clr", shift_clr_o, 0);
        check("rst_par", din_parallel_o, 0);
        check_idle("rst");

        // serial word with a 5-cycle gap
        send_word(24'h234567, 1'b0, 4'd5);
        check_shift(24'h234567, -1);
        check_gap(5);
        exp_cnt = 1;
        check_idle("w1");

        // back-to-back alternating words with no gap: exactly one idle cycle between
        send_word(24'haaaaaa, 1'b0, 4'd0);
        check_shift(24'haaaaaa, -1);
        exp_cnt = 2;
        check_idle("b2b_mid");
        send_word(24'h555555, 1'b0, 4'd0);
        check_shift(24'h555555, -1);
        exp_cnt = 3;
        check_idle("b2b_end");

        // parallel load, no gap
        send_word(24'ha5aa5a, 1'b1, 4'd0);
        check("ld_pulse", shift_ld_o, 1);
        check("ld_data", din_parallel_o, 24'ha5aa5a);
        check("ld_no_en", shift_en_o, 0);
        check("ld_ready", word_ready_o, 0);
        @(negedge clk);
        check("ld_after", shift_ld_o, 0);
        check("ld_par_zero", din_parallel_o, 0);
        exp_cnt = 4;
        check_idle("ld");

        // parallel load followed by a 3-cycle gap
        send_word(24'h0f0f0f, 1'b1, 4'd3);
        check("ld2_pulse", shift_ld_o, 1);
        check("ld2_data", din_parallel_o, 24'h0f0f0f);
        @(negedge clk);
        check_gap(3);
        exp_cnt = 5;
        check_idle("ld2");

        // clear requested mid-shift with the next word already waiting
        check("pre_clr_ready", word_ready_o, 1);
        word_i       = 24'h00ff00;
        load_mode_i  = 1'b0;
        gap_cycles_i = 4'd2;
        word_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_i = 24'h123456;
        gap_cycles_i = 4'd0;
        check_shift(24'h00ff00, 10);
        check_gap(2);
        exp_cnt = 6;
        check("clr_idle_ready", word_ready_o, 0);
        check("clr_idle_clr", shift_clr_o, 0);
        check("clr_idle_cnt", word_cnt_o, exp_cnt);
        @(negedge clk);
        check("clr_pulse", shift_clr_o, 1);
        check("clr_pulse_ready", word_ready_o, 0);
        check("clr_pulse_en", shift_en_o, 0);
        @(negedge clk);
        check("clr_done", shift_clr_o, 0);
        check("clr_done_ready", word_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        word_valid_i = 1'b0;
        check_shift(24'h123456, -1);
        exp_cnt = 7;
        check_idle("after_clr");

        // clear requested in idle blocks ready combinationally and pulses once
        clr_req_i = 1'b1;
        #1;
        check("idle_clr_ready", word_ready_o, 0);
        @(negedge clk);
        clr_req_i = 1'b0;
        check("idle_clr_pulse", shift_clr_o, 1);
        @(negedge clk);
        check("idle_clr_once", shift_clr_o, 0);
        check_idle("idle_clr");

        // reset in the middle of a shift
        send_word(24'hc3c3c3, 1'b0, 4'd3);
        repeat (10) @(negedge clk);
        check("pre_rst_en", shift_en_o, 1);
        reset_i = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        check("mid_rst_en", shift_en_o, 0);
        check("mid_rst_din", din_o, 0);
        check("mid_rst_ld", shift_ld_o, 0);
        check("mid_rst_clr", shift_clr_o, 0);
        check("mid_rst_par", din_parallel_o, 0);
        check("mid_rst_cnt", word_cnt_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // single set LSB: last serial cycle is 1 with or without the parity bit
        send_word(24'h000001, 1'b0, 4'd0);
        check_shift(24'h000001, -1);
        exp_cnt = 1;
        check_idle("lsb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
